// File: rtl/gate_result_serializer_if.sv
// Handshake bundle between the gate block, the serializer and the narrow consumer:
// a frame-in port (c1..c4) and a lane-out beat port.
interface gate_result_serializer_if #(
    parameter int unsigned W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    logic [W-1:0] c3;
    logic [W-1:0] c4;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_lane;
    logic         out_last;

    // Serializer side
    modport slave (
        input  in_valid, c1, c2, c3, c4, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last
    );

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, c1, c2, c3, c4, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last
    );
endinterface

// File: rtl/gate_result_serializer.sv
// Captures a four-lane gate result frame and replays it one lane per beat,
// lane 0 first, counting every fully emitted frame.
module gate_result_serializer #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_result_serializer_if.slave bus,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int unsigned LANES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         lane_q, lane_d;
    logic [1:0]         lane_nxt;
    logic [W-1:0]       cap_q [LANES];
    logic [W-1:0]       cap_d [LANES];
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic [1:0]         out_lane_q, out_lane_d;
    logic               out_last_q, out_last_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= 2'd0;
            for (int i = 0; i < LANES; i++) begin
                cap_q[i] <= '0;
            end
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= 2'd0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            cap_q       <= cap_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next state and next registered outputs; c1..c4 are only looked at on acceptance,
    // so unknowns on the inputs outside that cycle never reach the outputs.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        cap_d       = cap_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        out_last_d  = out_last_q;
        frame_cnt_d = frame_cnt_q;
        lane_nxt    = lane_q + 2'd1;

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (bus.in_valid && in_ready_q) begin
                    cap_d[0]    = bus.c1;
                    cap_d[1]    = bus.c2;
                    cap_d[2]    = bus.c3;
                    cap_d[3]    = bus.c4;
                    lane_d      = 2'd0;
                    state_d     = SEND;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = bus.c1;
                    out_lane_d  = 2'd0;
                    out_last_d  = 1'b0;
                end
            end
            SEND: begin
                in_ready_d  = 1'b0;
                if (out_valid_q && bus.out_ready) begin
                    if (lane_q == 2'd3) begin
                        // Last beat taken; the IDLE bubble keeps in_ready off the out_ready path
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        state_d     = IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        lane_d      = lane_nxt;
                        out_data_d  = cap_q[lane_nxt];
                        out_lane_d  = lane_nxt;
                        out_last_d  = (lane_nxt == 2'd3);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_lane  = out_lane_q;
    assign bus.out_last  = out_last_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_gate_result_serializer.sv
// Directed bench for gate_result_serializer: reset, single frame, stall,
// back-to-back frames, mid-frame reset and frame counter wrap.
module tb_gate_result_serializer;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] frame_cnt;
    int               checks;
    int               errors;

    gate_result_serializer_if #(.W(W)) bus ();

    gate_result_serializer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; everything is driven and sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
        bus.c1 = a;
        bus.c2 = b;
        bus.c3 = c;
        bus.c4 = d;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_frame(4'h0, 4'h0, 4'h0, 4'h0);
        step();
        step();
        rst_n = 1'b1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
        checks++; if (bus.out_lane !== 2'd0) begin errors++; $display("FAIL reset_out_lane got %0d want 0", bus.out_lane); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        // Unknown gate results while idle and not accepting must not leak out
        bus.c1 = 'x; bus.c2 = 'x; bus.c3 = 'x; bus.c4 = 'x;
        step();
        step();
        checks++; if (bus.out_data !== 4'h0) begin errors++; $display("FAIL idle_x_out_data got %h want 0", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_x_out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_single_frame();
        logic [3:0] exp [4];
        exp[0] = 4'h0; exp[1] = 4'hF; exp[2] = 4'hF; exp[3] = 4'hF;
        drive_frame(exp[0], exp[1], exp[2], exp[3]);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %b want 1", i, bus.out_valid); end
            checks++; if (bus.out_lane !== 2'(i)) begin errors++; $display("FAIL single_lane beat %0d got %0d want %0d", i, bus.out_lane, i); end
            checks++; if (bus.out_data !== exp[i]) begin errors++; $display("FAIL single_data beat %0d got %h want %h", i, bus.out_data, exp[i]); end
            checks++; if (bus.out_last !== (i == 3)) begin errors++; $display("FAIL single_last beat %0d got %b want %b", i, bus.out_last, (i == 3)); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready beat %0d got %b want 0", i, bus.in_ready); end
            step();
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid got %b want 0", bus.out_valid); end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_end_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_stall();
        drive_frame(4'h4, 4'hF, 4'hB, 4'hB);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        // Inputs change during SEND and must be ignored
        drive_frame(4'h1, 4'h2, 4'h3, 4'h6);
        checks++; if (bus.out_data !== 4'h4) begin errors++; $display("FAIL stall_lane0_data got %h want 4", bus.out_data); end
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cycle %0d got %b want 1", i, bus.out_valid); end
            checks++; if (bus.out_lane !== 2'd1) begin errors++; $display("FAIL stall_lane cycle %0d got %0d want 1", i, bus.out_lane); end
            checks++; if (bus.out_data !== 4'hF) begin errors++; $display("FAIL stall_data cycle %0d got %h want F", i, bus.out_data); end
            checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL stall_last cycle %0d got %b want 0", i, bus.out_last); end
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_lane !== 2'd2 || bus.out_data !== 4'hB) begin errors++; $display("FAIL stall_lane2 got lane %0d data %h want lane 2 data B", bus.out_lane, bus.out_data); end
        step();
        checks++; if (bus.out_lane !== 2'd3 || bus.out_data !== 4'hB || bus.out_last !== 1'b1) begin errors++; $display("FAIL stall_lane3 got lane %0d data %h last %b want lane 3 data B last 1", bus.out_lane, bus.out_data, bus.out_last); end
        step();
        checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL stall_frame_cnt got %0d want 2", frame_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_end_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp [8];
        exp[0] = 4'h8; exp[1] = 4'hF; exp[2] = 4'h7; exp[3] = 4'h7;
        exp[4] = 4'h0; exp[5] = 4'hE; exp[6] = 4'hE; exp[7] = 4'hF;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive_frame(exp[0], exp[1], exp[2], exp[3]);
        step();
        drive_frame(exp[4], exp[5], exp[6], exp[7]);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                // Exactly one IDLE cycle separates the frames, then the second frame is taken
                checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_bubble got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
                step();
                bus.in_valid = 1'b0;
            end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_lane !== 2'(i % 4) || bus.out_data !== exp[i]) begin
                errors++; $display("FAIL b2b_beat %0d got valid %b lane %0d data %h want 1 %0d %h", i, bus.out_valid, bus.out_lane, bus.out_data, 1'b1, i % 4, exp[i]);
            end
            step();
        end
        // Two frames from the earlier tests plus two here
        checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL b2b_frame_cnt got %0d want 4", frame_cnt); end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp [4];
        exp[0] = 4'h1; exp[1] = 4'h3; exp[2] = 4'h2; exp[3] = 4'hE;
        drive_frame(4'h9, 4'hA, 4'hC, 4'hD);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        checks++; if (bus.out_lane !== 2'd2 || bus.out_data !== 4'hC) begin errors++; $display("FAIL midrst_pre got lane %0d data %h want 2 C", bus.out_lane, bus.out_data); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
        drive_frame(exp[0], exp[1], exp[2], exp[3]);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_lane !== 2'(i) || bus.out_data !== exp[i]) begin
                errors++; $display("FAIL midrst_beat %0d got valid %b lane %0d data %h want 1 %0d %h", i, bus.out_valid, bus.out_lane, bus.out_data, i, exp[i]);
            end
            step();
        end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL midrst_after_cnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive_frame(4'h5, 4'hA, 4'h5, 4'hA);
        // Each frame is one accept cycle plus four beats
        for (int f = 0; f < 255; f++) begin
            for (int k = 0; k < 5; k++) step();
        end
        checks++; if (frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", frame_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL wrap_idle_ready got %b want 1", bus.in_ready); end
        for (int k = 0; k < 5; k++) step();
        bus.in_valid = 1'b0;
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d want 0", frame_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_frame(4'h0, 4'h0, 4'h0, 4'h0);
        #1;
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_result_serializer.md
Name: gate_result_serializer

Overview:
- Downstream stage of the 4-bit bitwise gates block: consumes the four W-bit gate results (c1..c4) as one frame under a valid/ready handshake.
- Registers the frame and streams it out one lane per beat, lane 0 (c1) first, under a second valid/ready handshake.
- Feeds narrow consumers such as a display or log port.
- Counts completed frames.

Parameters:
W, 4, width of each gate result lane and of out_data
CNT_W, 8, width of the completed-frame counter

Ports:
clk  input  1  rising-edge clock; only clock in the block
rst_n  input  1  reset; synchronous and active-low
in_valid  input  1  upstream frame c1..c4 valid
in_ready  output  1  block can accept a frame this cycle
c1  input  W  gate result lane 0
c2  input  W  gate result lane 1
c3  input  W  gate result lane 2
c4  input  W  gate result lane 3
out_valid  output  1  out_data/out_lane/out_last valid
out_ready  input  1  downstream accepts current beat
out_data  output  W  current lane value
out_lane  output  2  index of current lane, 0..3
out_last  output  1  high on lane 3 beat
frame_cnt  output  CNT_W  number of frames fully emitted, wraps

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-low (rst_n sampled on the rising clk edge).
- Reset values, applied while rst_n=0 at a clk edge:
  - state=IDLE, in_ready=1, out_valid=0.
  - out_data=0, out_lane=0, out_last=0, frame_cnt=0, capture regs=0.
- FSM states: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture c1..c4 into regs L0..L3, set lane=0, go to SEND.
  - All outputs are registered. The first beat (out_valid=1, out_lane=0, out_data=c1) appears the cycle after acceptance, so input-to-first-beat latency is 1 cycle.
- SEND:
  - in_ready=0. in_valid and c1..c4 are ignored.
  - out_valid=1, out_data=L[lane], out_lane=lane, out_last=(lane==3).
  - Beat transfers when out_valid&&out_ready.
  - Transfer with lane<3: lane increments next cycle.
  - Transfer with lane==3: frame_cnt+1 (wraps from 2^CNT_W-1 to 0), go to IDLE, out_valid=0 next cycle.
  - out_ready=0 (stall): out_data, out_lane and out_last hold stable, and out_valid stays 1 until transfer.
- Throughput:
  - With out_ready held at 1, a frame occupies 1 accept cycle plus 4 beat cycles.
  - There is a mandatory 1-cycle IDLE bubble between frames, so in_ready is never combinationally dependent on out_ready.
- Capture regs are written only on acceptance. Input changes during SEND never affect emitted data.
- Reset mid-frame (rst_n=0 in SEND): the frame is discarded without completing, frame_cnt returns to 0, and the next cycle starts in IDLE.
- in_valid held high continuously: a new frame is accepted in each IDLE cycle, i.e. every 5th cycle when out_ready=1.
- X/unknown on c1..c4 while not accepting must not propagate to outputs.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, out_data=0, out_lane=0, frame_cnt=0.
- Single frame, out_ready=1: c1=0,c2=F,c3=F,c4=F (a=A,b=5) accepted at cycle t -> beats at t+1..t+4 carry lanes 0,1,2,3 with data 0,F,F,F; out_last only at t+4; frame_cnt=1 at t+5; in_ready=1 at t+5.
- Stall: frame c1=4,c2=F,c3=B,c4=B; hold out_ready=0 for 3 cycles during lane 1 -> out_data=F and out_lane=1 stable for 3 cycles; lanes 2,3 (B,B) follow when out_ready=1; input changes during SEND are ignored.
- Back-to-back: in_valid=1 constantly, frames {8,F,7,7} then {0,E,E,F} -> accepts spaced exactly 5 cycles apart; emitted sequence 8,F,7,7,0,E,E,F; frame_cnt=2.
- Reset mid-frame: assert rst_n=0 during lane 2 of a frame -> next cycle out_valid=0, frame_cnt=0, state IDLE; a subsequent frame {1,3,2,E} emits correctly from lane 0.
- Counter wrap: 256 frames with CNT_W=8 -> frame_cnt reads 255 after frame 255 and 0 after frame 256.
